cardinal_if_stage: RTL
======================

# cardinal_if_stage

Instruction-fetch stage of the Cardinal processor: owns the program counter, drives the 8-bit word address to the 256 x 32 instruction memory, and registers the returned instruction into the IF/ID pipeline register for the decode stage. Handles decode-stage stalls, taken-branch redirects with bubble insertion, and halt detection on the all-zero end-of-program NOP. It sits between `imem` (combinational read) and the decode stage inside `cardinal_processor`.

## Interface
- `PC_W`, 8, PC and instruction-address width (word addressed).
- `INSTR_W`, 32, instruction width.
- `RESET_PC`, 0, PC value loaded on reset.
- `CNT_W`, 16, width of the performance counters.

- `Clock`  in  1  system clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Instr_Addr`  out  [0:PC_W-1]  current PC to imem; equals the PC register, no logic in between.
- `Instruction`  in  [0:INSTR_W-1]  imem read data for `Instr_Addr`, valid in the same cycle.
- `Stall`  in  1  hold PC and IF/ID register (from ID hazard unit).
- `Br_Taken`  in  1  redirect fetch to `Br_Target` and flush IF/ID.
- `Br_Target`  in  [0:PC_W-1]  redirect address.
- `IF_ID_Instr`  out  [0:INSTR_W-1]  registered instruction.
- `IF_ID_PC`  out  [0:PC_W-1]  PC of `IF_ID_Instr`.
- `IF_ID_Valid`  out  1  registered slot holds a real instruction (0 = bubble).
- `Halt`  out  1  sticky; end-of-program NOP fetched, PC frozen.
- `Fetch_Count`  out  [0:CNT_W-1]  count of valid instructions loaded into IF/ID, saturating.
- `Stall_Count`  out  [0:CNT_W-1]  count of cycles with `Stall` high and no `Br_Taken`, saturating.

## Operation
- Reset values: PC = `RESET_PC`; `IF_ID_Instr` = 0, `IF_ID_PC` = 0, `IF_ID_Valid` = 0, `Halt` = 0, both counters = 0.
- Per-cycle priority: `Reset` > `Br_Taken` > `Stall` > `Halt` > normal fetch.
- Normal: IF/ID <= {`Instruction`, PC, valid = 1}; PC <= PC + 1, modulo 2^PC_W (8'hFF wraps to 8'h00); `Fetch_Count` += 1.
- `Br_Taken`: PC <= `Br_Target`; IF/ID <= {0, 0, valid = 0}; `Halt` <= 0. This applies even while `Stall` or `Halt` is high. A halt NOP fetched on a wrong path is thereby cancelled.
- `Stall` (without `Br_Taken`): PC and IF/ID hold; `Stall_Count` += 1; no halt detection that cycle.
- Halt detect: on a normal-fetch cycle with `Instruction` == 32'h00000000:
  - the NOP is latched with valid = 1;
  - `Halt` <= 1;
  - PC holds (it does not increment).
- While `Halt` = 1 (no branch, no stall): PC holds and IF/ID <= bubble (valid = 0). The NOP is therefore delivered to decode exactly once.
- Counters saturate at all-ones and do not wrap.

## Timing
- Fetch latency: 1 cycle. The instruction at PC appears on `IF_ID_*` after the next rising edge.
- The first edge after `Reset` deasserts latches the instruction at `RESET_PC`.
- `Br_Taken` and `Br_Target` are sampled at the edge. The instruction at `Br_Target` reaches `IF_ID_Instr` two edges after the branch is sampled, with one bubble in between.
- `Stall` takes effect at the same edge it is sampled. Its release resumes fetch at the held PC with no lost or duplicated instruction.
- `Reset` asserted mid-stream overrides all inputs at that edge.
- `Halt` rises at the edge that latches the NOP.

## Structure
- Shared package `cardinal_pkg` holds:
  - `PC_W`, `INSTR_W`;
  - the constant `HALT_NOP` = 32'h00000000;
  - `RESET_PC`;
  - the IF/ID bundle typedef (instr, pc, valid), which the decode stage reuses.
- One sub-module, `cardinal_sat_counter` (parameterised width, synchronous clear, increment enable, saturate), instantiated twice for the two counters.
- PC register, halt flag, and IF/ID register live in `cardinal_if_stage`.

## Test plan
- Reset, then imem[0..3] = 0x11111111, 0x22222222, 0x33333333, 0x00000000 -> IF/ID shows PC 0..3 in consecutive cycles; `Halt` = 1 after PC 3; `Instr_Addr` stays 3; `Fetch_Count` = 4; following cycles have `IF_ID_Valid` = 0.
- `Stall` high 3 cycles while PC = 5 -> PC stays 5; IF/ID holds PC 4 contents; `Stall_Count` = 3; after release the next IF/ID PC = 5.
- `Br_Taken` = 1 with `Br_Target` = 8'h40 at PC 7, simultaneous with `Stall` -> one bubble (valid = 0), then IF/ID PC = 0x40; `Stall_Count` unchanged.
- Fetch NOP at PC 9, then `Br_Taken` to 8'h20 two cycles later -> `Halt` drops to 0 and fetch resumes at 0x20.
- Start PC at 8'hFE with nonzero imem -> PC sequence FE, FF, 00, 01.
- `Reset` asserted mid-stream while halted -> all outputs return to their reset values at that edge; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cardinal_pkg.sv
// Shared Cardinal processor definitions: widths, halt encoding, IF/ID bundle.
package cardinal_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_PC = '0;
    localparam logic [INSTR_W-1:0] HALT_NOP = '0;

    // IF/ID pipeline register contents, also consumed by the decode stage.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/cardinal_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module cardinal_sat_counter
    import cardinal_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    logic [W-1:0] count_p0;

    // Add one unless already at the ceiling.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] value);
        if (&value) begin
            return value;
        end
        return value + 1'b1;
    endfunction

    // Counter register: clear on reset, otherwise saturating increment on Inc.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_p0 <= '0;
        end else if (Inc) begin
            count_p0 <= sat_inc(count_p0);
        end
    end

    assign Count = count_p0;

endmodule

// File: rtl/cardinal_if_stage.sv
// Cardinal instruction-fetch stage: PC, IF/ID register, halt detection, perf counters.
module cardinal_if_stage
    import cardinal_pkg::*;
#(
    parameter int               PC_W     = cardinal_pkg::PC_W,
    parameter int               INSTR_W  = cardinal_pkg::INSTR_W,
    parameter logic [PC_W-1:0]  RESET_PC = cardinal_pkg::RESET_PC,
    parameter int               CNT_W    = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic [0:PC_W-1]     Instr_Addr,
    input  logic [0:INSTR_W-1]  Instruction,
    input  logic                Stall,
    input  logic                Br_Taken,
    input  logic [0:PC_W-1]     Br_Target,
    output logic [0:INSTR_W-1]  IF_ID_Instr,
    output logic [0:PC_W-1]     IF_ID_PC,
    output logic                IF_ID_Valid,
    output logic                Halt,
    output logic [0:CNT_W-1]    Fetch_Count,
    output logic [0:CNT_W-1]    Stall_Count
);

    logic [PC_W-1:0] pc_p0;
    logic [PC_W-1:0] pc_nxt;
    if_id_t          if_id_p1;
    if_id_t          if_id_nxt;
    logic            halt_p1;
    logic            halt_nxt;
    logic            fetch_inc;
    logic            stall_inc;

    // Next-state selection in priority order: branch, stall, halted, normal fetch.
    always_comb begin
        pc_nxt    = pc_p0;
        if_id_nxt = if_id_p1;
        halt_nxt  = halt_p1;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        if (Br_Taken) begin
            // Redirect also cancels a halt reached down a wrong path.
            pc_nxt    = Br_Target;
            if_id_nxt = '0;
            halt_nxt  = 1'b0;
        end else if (Stall) begin
            stall_inc = 1'b1;
        end else if (halt_p1) begin
            if_id_nxt = '0;
        end else begin
            if_id_nxt.instr = Instruction;
            if_id_nxt.pc    = pc_p0;
            if_id_nxt.valid = 1'b1;
            fetch_inc       = 1'b1;
            // The end-of-program NOP freezes the PC on itself.
            if (Instruction == HALT_NOP) begin
                halt_nxt = 1'b1;
            end else begin
                pc_nxt = pc_p0 + 1'b1;
            end
        end
    end

    // ---- IF -> ID boundary ----
    // PC, halt flag and IF/ID register update.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_p0    <= RESET_PC;
            if_id_p1 <= '0;
            halt_p1  <= 1'b0;
        end else begin
            pc_p0    <= pc_nxt;
            if_id_p1 <= if_id_nxt;
            halt_p1  <= halt_nxt;
        end
    end

    cardinal_sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .Inc   (fetch_inc),
        .Count (Fetch_Count)
    );

    cardinal_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .Inc   (stall_inc),
        .Count (Stall_Count)
    );

    assign Instr_Addr  = pc_p0;
    assign IF_ID_Instr = if_id_p1.instr;
    assign IF_ID_PC    = if_id_p1.pc;
    assign IF_ID_Valid = if_id_p1.valid;
    assign Halt        = halt_p1;

endmodule
